fila_instrucoes: RTL and testbench

FILA_INSTRUCOES -- requirements
Module: fila_instrucoes

---
 rtl/fila_instrucoes.sv | 74 +++++++
 tb/tb_fila_instrucoes.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fila_instrucoes.sv
// Circular instruction queue between fetch and dispatch: registered pointers and occupancy,
// no bypass (an enqueued word is visible the cycle after), Pronta_Entrada = not full.
module fila_instrucoes #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARGURA      = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [LARGURA-1:0]            i_instrucao_entrada,
  input  logic                          i_valida_entrada,
  output logic                          o_pronta_entrada,
  output logic [LARGURA-1:0]            o_instrucao_despachada,
  output logic                          o_valida_despacho,
  input  logic                          i_despacha,
  input  logic                          i_flush,
  output logic [$clog2(PROFUNDIDADE):0] o_ocupacao,
  output logic                          o_cheia,
  output logic                          o_vazia
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0] LP_CHEIO = (PW+1)'(PROFUNDIDADE);
  localparam logic [PW:0] LP_UM    = (PW+1)'(1);

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_ocup;

  logic w_cheia;
  logic w_vazia;
  logic w_enq;
  logic w_deq;

  // Full/empty come from registered occupancy only, so a same-cycle dequeue
  // never opens a slot for the offered instruction.
  assign w_cheia = (r_ocup == LP_CHEIO);
  assign w_vazia = (r_ocup == '0);
  assign w_enq   = i_valida_entrada && !w_cheia;
  assign w_deq   = i_despacha && !w_vazia;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ocup   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ocup   <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_ocup <= r_ocup + LP_UM;
        2'b01:   r_ocup <= r_ocup - LP_UM;
        default: r_ocup <= r_ocup;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge i_clock) begin
    if (i_reset && !i_flush && w_enq) r_mem[r_wr_ptr] <= i_instrucao_entrada;
  end

  assign o_pronta_entrada       = !w_cheia;
  assign o_valida_despacho      = !w_vazia;
  assign o_instrucao_despachada = w_vazia ? '0 : r_mem[r_rd_ptr];
  assign o_ocupacao             = r_ocup;
  assign o_cheia                = w_cheia;
  assign o_vazia                = w_vazia;

endmodule

// File: tb/tb_fila_instrucoes.sv
// Scoreboard bench for fila_instrucoes (PROFUNDIDADE=4, LARGURA=16).
module tb_fila_instrucoes;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        vld = 1'b0;
  logic        pronta;
  logic [15:0] dout;
  logic        valida;
  logic        desp = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  ocup;
  logic        cheia;
  logic        vazia;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] sb[$];
  int          m_ocup = 0;

  fila_instrucoes #(.PROFUNDIDADE(4), .LARGURA(16)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_instrucao_entrada(din), .i_valida_entrada(vld), .o_pronta_entrada(pronta),
    .o_instrucao_despachada(dout), .o_valida_despacho(valida),
    .i_despacha(desp), .i_flush(flush),
    .o_ocupacao(ocup), .o_cheia(cheia), .o_vazia(vazia)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus. The dispatched word is sampled before the edge
  // and compared against the scoreboard head whenever a dequeue is expected.
  task automatic passo(input logic v, input logic [15:0] d, input logic ds, input logic fl);
    logic m_enq;
    logic m_deq;
    logic [15:0] esperado;
    vld = v; din = d; desp = ds; flush = fl;
    m_enq = v && (m_ocup != DEPTH);
    m_deq = ds && (m_ocup != 0);
    #1;
    if (m_deq && !fl) begin
      esperado = sb.pop_front();
      n_cmp++;
      if (dout !== esperado) begin
        n_err++;
        $display("FAIL scoreboard_dispatch got %h expected %h", dout, esperado);
      end
    end
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      m_ocup = 0;
    end else begin
      if (m_enq) sb.push_back(d);
      m_ocup = m_ocup + (m_enq ? 1 : 0) - (m_deq ? 1 : 0);
    end
    vld = 1'b0; desp = 1'b0; flush = 1'b0; din = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_cmp++; if (ocup !== 3'd0)     begin n_err++; $display("FAIL reset_ocup got %0d expected 0", ocup); end
    n_cmp++; if (vazia !== 1'b1)    begin n_err++; $display("FAIL reset_vazia got %b expected 1", vazia); end
    n_cmp++; if (cheia !== 1'b0)    begin n_err++; $display("FAIL reset_cheia got %b expected 0", cheia); end
    n_cmp++; if (pronta !== 1'b1)   begin n_err++; $display("FAIL reset_pronta got %b expected 1", pronta); end
    n_cmp++; if (valida !== 1'b0)   begin n_err++; $display("FAIL reset_valida got %b expected 0", valida); end
    n_cmp++; if (dout !== 16'h0000) begin n_err++; $display("FAIL reset_dout got %h expected 0000", dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete(); m_ocup = 0;
  endtask

  task automatic test_enqueue_single;
    passo(1'b1, 16'hA001, 1'b0, 1'b0);
    n_cmp++; if (valida !== 1'b1)   begin n_err++; $display("FAIL single_valida got %b expected 1", valida); end
    n_cmp++; if (dout !== 16'hA001) begin n_err++; $display("FAIL single_dout got %h expected a001", dout); end
    n_cmp++; if (ocup !== 3'd1)     begin n_err++; $display("FAIL single_ocup got %0d expected 1", ocup); end
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (vazia !== 1'b1)    begin n_err++; $display("FAIL single_drain_vazia got %b expected 1", vazia); end
  endtask

  task automatic test_full;
    for (int i = 1; i <= 4; i++) passo(1'b1, 16'(i), 1'b0, 1'b0);
    n_cmp++; if (cheia !== 1'b1)  begin n_err++; $display("FAIL full_cheia got %b expected 1", cheia); end
    n_cmp++; if (pronta !== 1'b0) begin n_err++; $display("FAIL full_pronta got %b expected 0", pronta); end
    n_cmp++; if (ocup !== 3'd4)   begin n_err++; $display("FAIL full_ocup got %0d expected 4", ocup); end
    passo(1'b1, 16'h0005, 1'b0, 1'b0);
    n_cmp++; if (ocup !== 3'd4)   begin n_err++; $display("FAIL full_offer_ocup got %0d expected 4", ocup); end
    n_cmp++; if (dout !== 16'h0001) begin n_err++; $display("FAIL full_offer_head got %h expected 0001", dout); end
    for (int i = 0; i < 4; i++) passo(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (vazia !== 1'b1)  begin n_err++; $display("FAIL full_drain_vazia got %b expected 1", vazia); end
    n_cmp++; if (sb.size() != 0)  begin n_err++; $display("FAIL full_drain_sb got %0d expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    passo(1'b1, 16'hB000, 1'b0, 1'b0);
    passo(1'b1, 16'hB001, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      passo(1'b1, 16'hB002 + 16'(i), 1'b1, 1'b0);
      n_cmp++;
      if (ocup !== 3'd2) begin n_err++; $display("FAIL b2b_ocup cycle %0d got %0d expected 2", i, ocup); end
    end
    n_cmp++; if (dout !== 16'hB006) begin n_err++; $display("FAIL b2b_head got %h expected b006", dout); end
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (ocup !== 3'd0) begin n_err++; $display("FAIL b2b_empty_desp got %0d expected 0", ocup); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) passo(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
    passo(1'b1, 16'hC0FF, 1'b1, 1'b1);
    n_cmp++; if (ocup !== 3'd0)     begin n_err++; $display("FAIL flush_ocup got %0d expected 0", ocup); end
    n_cmp++; if (valida !== 1'b0)   begin n_err++; $display("FAIL flush_valida got %b expected 0", valida); end
    n_cmp++; if (dout !== 16'h0000) begin n_err++; $display("FAIL flush_dout got %h expected 0000", dout); end
    passo(1'b1, 16'hC100, 1'b0, 1'b0);
    n_cmp++; if (dout !== 16'hC100) begin n_err++; $display("FAIL flush_refill got %h expected c100", dout); end
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    passo(1'b1, 16'hD001, 1'b0, 1'b0);
    passo(1'b1, 16'hD002, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ocup !== 3'd0)     begin n_err++; $display("FAIL async_ocup got %0d expected 0", ocup); end
    n_cmp++; if (valida !== 1'b0)   begin n_err++; $display("FAIL async_valida got %b expected 0", valida); end
    n_cmp++; if (dout !== 16'h0000) begin n_err++; $display("FAIL async_dout got %h expected 0000", dout); end
    n_cmp++; if (pronta !== 1'b1)   begin n_err++; $display("FAIL async_pronta got %b expected 1", pronta); end
    #1;
    rst_n = 1'b1;
    sb.delete(); m_ocup = 0;
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (ocup !== 3'd0)  begin n_err++; $display("FAIL empty_desp_ocup got %0d expected 0", ocup); end
    n_cmp++; if (vazia !== 1'b1) begin n_err++; $display("FAIL empty_desp_vazia got %b expected 1", vazia); end
    passo(1'b1, 16'hD00D, 1'b0, 1'b0);
    n_cmp++; if (dout !== 16'hD00D) begin n_err++; $display("FAIL post_reset_enq got %h expected d00d", dout); end
    passo(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_full_simultaneous;
    for (int i = 0; i < 4; i++) passo(1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
    passo(1'b1, 16'hE004, 1'b1, 1'b0);
    n_cmp++; if (ocup !== 3'd3)     begin n_err++; $display("FAIL fullsim_ocup got %0d expected 3", ocup); end
    n_cmp++; if (dout !== 16'hE001) begin n_err++; $display("FAIL fullsim_head got %h expected e001", dout); end
    passo(1'b1, 16'hE004, 1'b0, 1'b0);
    n_cmp++; if (ocup !== 3'd4)     begin n_err++; $display("FAIL fullsim_accept got %0d expected 4", ocup); end
    for (int i = 0; i < 4; i++) passo(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (vazia !== 1'b1)    begin n_err++; $display("FAIL fullsim_drain got %b expected 1", vazia); end
  endtask

  initial begin
    test_reset();
    test_enqueue_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_full_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
